// File: rtl/xbus_pkg.sv
// Shared XBus definitions: word width, legal value range and data-port FSM states.
package xbus_pkg;

  localparam int XBUS_WIDTH = 11;
  localparam int XBUS_MAX   = 999;
  localparam int XBUS_MIN   = -999;

  typedef enum logic {
    FETCH = 1'b0,
    READY = 1'b1
  } data_state_e;

endpackage

// File: rtl/xbus_port_responder.sv
// Responder side of one blocking XBus port: offer/accept flags and transfer strobes.
module xbus_port_responder (
  input  logic wr_i,
  input  logic rd_i,
  input  logic accept_en_i,
  input  logic offer_en_i,
  output logic read_o,
  output logic write_o,
  output logic wr_done_o,
  output logic rd_done_o
);

  assign read_o    = accept_en_i;
  assign write_o   = offer_en_i;
  assign wr_done_o = wr_i & accept_en_i;
  // An MC write always takes priority; a simultaneous read stays pending.
  assign rd_done_o = rd_i & offer_en_i & ~wr_done_o;

endmodule

// File: rtl/xbus_ram.sv
// XBus RAM peripheral: pointer-addressed word store with an address port and an
// auto-incrementing data port, both acting as blocking XBus responders.
module xbus_ram
  import xbus_pkg::*;
#(
  parameter int WIDTH = XBUS_WIDTH,
  parameter int DEPTH = 14,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_write_in,
  input  logic             a_read_in,
  output logic [WIDTH-1:0] a_out,
  output logic             a_write_out,
  output logic             a_read_out,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_write_in,
  input  logic             d_read_in,
  output logic [WIDTH-1:0] d_out,
  output logic             d_write_out,
  output logic             d_read_out
);

  logic             active_q;
  data_state_e      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] ptr_inc;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] d_out_q;
  logic             d_ready;
  logic             a_wr_done, unused_a_rd_done;
  logic             d_wr_done, d_rd_done;
  logic             a_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) active_q <= 1'b0;
    else          active_q <= 1'b1;
  end

  xbus_port_responder u_a_port (
    .wr_i        (a_write_in),
    .rd_i        (a_read_in),
    .accept_en_i (active_q),
    .offer_en_i  (active_q),
    .read_o      (a_read_out),
    .write_o     (a_write_out),
    .wr_done_o   (a_wr_done),
    .rd_done_o   (unused_a_rd_done)
  );

  xbus_port_responder u_d_port (
    .wr_i        (d_write_in),
    .rd_i        (d_read_in),
    .accept_en_i (d_ready),
    .offer_en_i  (d_ready),
    .read_o      (d_read_out),
    .write_o     (d_write_out),
    .wr_done_o   (d_wr_done),
    .rd_done_o   (d_rd_done)
  );

  // Out-of-range address writes (negative or >= DEPTH) complete but change nothing.
  assign a_valid = a_wr_done && !a_in[WIDTH-1] && (a_in <= WIDTH'(DEPTH - 1));
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign a_out   = {{(WIDTH - PTR_W){1'b0}}, ptr_q};
  assign d_out   = d_out_q;

  always_comb begin
    ptr_d = ptr_q;
    if (d_wr_done || d_rd_done) ptr_d = ptr_inc;
    if (a_valid)                ptr_d = a_in[PTR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // A valid address write always re-fetches so d_out never shows a stale cell.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = READY;
      READY:   if (d_wr_done || d_rd_done) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (a_valid) state_d = FETCH;
  end

  always_comb begin
    d_ready = (state_q == READY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_out_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (state_q == FETCH) d_out_q <= mem_q[ptr_q];
      if (d_wr_done)        mem_q[ptr_q] <= d_in;
    end
  end

endmodule

// File: tb/tb_xbus_ram.sv
// Directed self-checking bench for xbus_ram driving both XBus ports as the MC.
module tb_xbus_ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] a_in, d_in;
  logic        a_write_in, a_read_in, d_write_in, d_read_in;
  logic [10:0] a_out, d_out;
  logic        a_write_out, a_read_out, d_write_out, d_read_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xbus_ram dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .a_in        (a_in),
    .a_write_in  (a_write_in),
    .a_read_in   (a_read_in),
    .a_out       (a_out),
    .a_write_out (a_write_out),
    .a_read_out  (a_read_out),
    .d_in        (d_in),
    .d_write_in  (d_write_in),
    .d_read_in   (d_read_in),
    .d_out       (d_out),
    .d_write_out (d_write_out),
    .d_read_out  (d_read_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && !d_write_out; i++) tick();
    if (!d_write_out) check("ready_timeout", 32'(d_write_out), 32'd1);
  endtask

  task automatic addr_write(input logic [10:0] v);
    a_in = v;
    a_write_in = 1'b1;
    tick();
    a_write_in = 1'b0;
  endtask

  task automatic data_write(input logic [10:0] v);
    wait_ready();
    d_in = v;
    d_write_in = 1'b1;
    tick();
    d_write_in = 1'b0;
  endtask

  task automatic data_read(output logic [10:0] v);
    wait_ready();
    v = d_out;
    d_read_in = 1'b1;
    tick();
    d_read_in = 1'b0;
  endtask

  logic [10:0] rv;

  initial begin
    reset_n = 1'b0;
    a_in = '0; d_in = '0;
    a_write_in = 1'b0; a_read_in = 1'b0; d_write_in = 1'b0; d_read_in = 1'b0;
    tick();
    tick();
    check("rst_a_write_out", 32'(a_write_out), 32'd0);
    check("rst_a_read_out",  32'(a_read_out),  32'd0);
    check("rst_d_write_out", 32'(d_write_out), 32'd0);
    check("rst_d_read_out",  32'(d_read_out),  32'd0);
    check("rst_a_out",       32'(a_out),       32'd0);
    check("rst_d_out",       32'(d_out),       32'd0);

    reset_n = 1'b1;
    tick();
    check("rel_a_write_out", 32'(a_write_out), 32'd1);
    check("rel_a_read_out",  32'(a_read_out),  32'd1);
    check("rel_d_write_out", 32'(d_write_out), 32'd1);
    check("rel_a_out",       32'(a_out),       32'd0);
    check("rel_d_out",       32'(d_out),       32'd0);

    // Pointer load then two data writes with one-cycle FETCH gaps.
    addr_write(11'd5);
    check("aw5_ptr",   32'(a_out),       32'd5);
    check("aw5_fetch", 32'(d_write_out), 32'd0);
    data_write(11'd100);
    check("dw100_gap", 32'(d_write_out), 32'd0);
    check("dw100_ptr", 32'(a_out),       32'd6);
    tick();
    check("dw100_rdy", 32'(d_write_out), 32'd1);
    data_write(11'd200);
    check("dw200_gap", 32'(d_write_out), 32'd0);
    tick();
    check("dw200_rdy", 32'(d_write_out), 32'd1);
    check("dw200_ptr", 32'(a_out),       32'd7);
    addr_write(11'd5);
    data_read(rv);
    check("mem5",      32'(rv),    32'd100);
    data_read(rv);
    check("mem6",      32'(rv),    32'd200);
    check("rd_ptr7",   32'(a_out), 32'd7);

    // Wrap from the last cell.
    addr_write(11'd13);
    data_write(11'h7F9);
    check("wrap_ptr0", 32'(a_out), 32'd0);
    data_read(rv);
    check("wrap_mem0", 32'(rv),    32'd0);
    check("wrap_ptr1", 32'(a_out), 32'd1);
    addr_write(11'd13);
    data_read(rv);
    check("mem13",     32'(rv),    32'h7F9);
    check("mem13_ptr", 32'(a_out), 32'd0);

    // Out-of-range address writes are consumed and ignored.
    a_in = 11'd14; a_write_in = 1'b1;
    #1 check("aw14_accept", 32'(a_read_out), 32'd1);
    tick();
    a_write_in = 1'b0;
    check("aw14_ptr", 32'(a_out), 32'd0);
    a_in = 11'h7FF; a_write_in = 1'b1;
    #1 check("awneg_accept", 32'(a_read_out), 32'd1);
    tick();
    a_write_in = 1'b0;
    check("awneg_ptr", 32'(a_out), 32'd0);
    a_read_in = 1'b1;
    #1 check("ar_offer", 32'(a_write_out), 32'd1);
    tick();
    a_read_in = 1'b0;
    check("ar_ptr", 32'(a_out), 32'd0);

    // Same-cycle address write and data read.
    addr_write(11'd9);
    data_write(11'd55);
    addr_write(11'd3);
    data_write(11'd33);
    addr_write(11'd9);
    wait_ready();
    check("same_rd_val", 32'(d_out), 32'd55);
    a_in = 11'd3; a_write_in = 1'b1; d_read_in = 1'b1;
    tick();
    a_write_in = 1'b0; d_read_in = 1'b0;
    check("same_ptr",   32'(a_out),       32'd3);
    check("same_fetch", 32'(d_write_out), 32'd0);
    wait_ready();
    check("same_dout",  32'(d_out),       32'd33);

    // Both data flags: write wins, single increment.
    addr_write(11'd2);
    wait_ready();
    d_in = 11'd77; d_write_in = 1'b1; d_read_in = 1'b1;
    tick();
    d_write_in = 1'b0; d_read_in = 1'b0;
    check("both_ptr", 32'(a_out), 32'd3);
    addr_write(11'd2);
    data_read(rv);
    check("both_mem2", 32'(rv), 32'd77);

    // Asynchronous reset while in FETCH.
    addr_write(11'd5);
    check("pre_rst_fetch", 32'(d_write_out), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ptr",         32'(a_out),       32'd0);
    check("arst_d_write_out", 32'(d_write_out), 32'd0);
    check("arst_a_write_out", 32'(a_write_out), 32'd0);
    tick();
    reset_n = 1'b1;
    addr_write(11'd5);
    data_read(rv);
    check("arst_mem5", 32'(rv), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xbus_ram.md
Name: xbus_ram

Overview:
- XBus responder peripheral: a 14-word RAM with one address port (a) and one data port (d).
- Each port sits at the far end of an MC's x0/x1 pin pair. It answers MC writes (accept) and MC reads (offer data) using the blocking XBus handshake.
- An internal pointer selects the cell. Every data-port transfer auto-increments the pointer.

Parameters:
- WIDTH, 11, XBus word width (signed, two's complement)
- DEPTH, 14, number of RAM cells
- PTR_W, 4, pointer width; must satisfy 2**PTR_W >= DEPTH

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- a_in  input  WIDTH  value driven by MC on the address port
- a_write_in  input  1  MC is writing a_in (held until transfer)
- a_read_in  input  1  MC wants to read the address port
- a_out  output  WIDTH  current pointer, zero-extended
- a_write_out  output  1  responder is offering a_out
- a_read_out  output  1  responder will accept a_in
- d_in  input  WIDTH  value driven by MC on the data port
- d_write_in  input  1  MC is writing d_in
- d_read_in  input  1  MC wants to read the data port
- d_out  output  WIDTH  registered copy of mem[ptr]
- d_write_out  output  1  responder is offering d_out
- d_read_out  output  1  responder will accept d_in

Behaviour:
- Handshake rule (both ports): a transfer completes on the rising clk edge where the writer's write flag and the reader's read flag are both 1. Otherwise there is no effect, and the MC holds its flags/data.
- Reset (async, reset_n=0):
  - ptr=0, all mem cells=0, d_out=0, data FSM=FETCH.
  - a_write_out=0, a_read_out=0, d_write_out=0, d_read_out=0.
- Address port:
  - After reset release, a_write_out=1 and a_read_out=1 permanently; a_out={0,ptr} combinationally.
  - MC write (a_write_in & a_read_out): if 0 <= a_in <= DEPTH-1, ptr <= a_in[PTR_W-1:0]; any other value (negative or >= DEPTH) is consumed and ignored.
  - MC read (a_read_in & a_write_out): completes, no state change.
  - If both a_write_in and a_read_in are 1, only the write completes.
- Data port FSM, two states:
  - FETCH: d_write_out=0, d_read_out=0; d_out <= mem[ptr]; next state READY. No transfer can complete in FETCH.
  - READY: d_write_out=1, d_read_out=1.
    - On MC read (d_read_in): transfer completes with d_out; ptr <= ptr+1; next state FETCH.
    - On MC write (d_write_in): mem[ptr] <= d_in; ptr <= ptr+1; next state FETCH.
    - If both flags are 1: the write wins; the read does not complete.
    - Otherwise remain in READY.
- Latency:
  - First data offer is one cycle after reset release.
  - Back-to-back data transfers are at most every 2 cycles.
  - Address transfers complete every cycle.
- Pointer wrap: ptr == DEPTH-1 increments to 0, never to DEPTH.
- Same-cycle address write and data transfer:
  - The data transfer uses the old ptr (mem write or d_out already valid).
  - The address write sets the new ptr; the auto-increment is discarded.
  - The data FSM still enters FETCH, so the next d_out = mem[new ptr].
- An address write (valid value) while the data FSM is in READY forces FETCH next cycle, so d_out never shows a stale cell. This also applies to an address write while the data FSM is already in FETCH.
- Reset mid-transfer: all state returns to reset values immediately; a pending MC flag completes no transfer until READY is reached.
- Stored values are raw WIDTH-bit words; no clamping.

Decomposition:
- Shared package (xbus_pkg): XBUS_WIDTH=11, XBUS_MAX=999, XBUS_MIN=-999, and the enum for the data FSM states {FETCH, READY}.
- One natural sub-module: xbus_port_responder. It holds the per-port handshake logic (accept/offer flags, write-over-read priority, transfer-done strobes) and is instantiated twice; the RAM array, pointer and FSM stay in xbus_ram.

Test Plan:
- Reset then release: cycle 0 all outputs 0; cycle 1 a_write_out=1, a_out=0, d_write_out=1, d_out=0.
- Address write a_in=5, then data writes 100, 200: mem[5]=100, mem[6]=200, ptr=7; the d port shows d_write_out=0 for exactly 1 cycle after each transfer.
- Address write 13, data write -7, data read: mem[13]=-7 (11'h7F9); ptr wraps to 0; the read returns mem[0]=0 and ptr=1.
- Address write 14, then address write -1: ptr unchanged (stays 0), a_read_out stays 1, both transfers complete.
- Same cycle: address write 3 and data read with ptr=9: the read returns mem[9], final ptr=3, and the next d_out = mem[3].
- Data port d_write_in=1 and d_read_in=1 with ptr=2: mem[2]=d_in, the read does not complete, ptr=3. Assert reset_n=0 mid-FETCH: ptr=0 and d_write_out=0 asynchronously.
